bm_dag_stim_sig: RTL and testbench
==================================

# bm_dag_stim_sig

Self-contained stimulus generator and response compactor for the DAG micro-benchmarks. It drives pseudo-random operand vectors into a benchmark's `a_in`/`b_in`/`c_in`/`d_in` inputs and folds the benchmark's `out0`/`out1` responses into a 16-bit MISR signature. Responses are captured after a fixed pipeline latency. It sits opposite the benchmark under test and closes the loop so that synthesized netlists can be compared against RTL by signature alone.

## Interface
- `BITS`, 2: operand width; must satisfy 2*BITS+2 <= 16.
- `SEED`, 16'hACE1: LFSR load value; 0 is replaced by 16'hACE1.
- `RUN_LEN`, 64: number of vectors per run, 1..65535.
- `LAT`, 3: clocks from vector presentation to matching response, 0..15.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level request to begin a run.
- `a_out`  out  BITS  operand A stimulus.
- `b_out`  out  BITS  operand B stimulus.
- `c_out`  out  1  control stimulus C.
- `d_out`  out  1  control stimulus D.
- `resp0_in`  in  BITS  benchmark `out0`.
- `resp1_in`  in  1  benchmark `out1`.
- `busy`  out  1  high in DRIVE or DRAIN.
- `done`  out  1  high in DONE.
- `signature`  out  16  MISR contents.

## Operation
- States: IDLE, DRIVE, DRAIN, DONE. Reset forces IDLE. All outputs read 0 while reset is applied and on the first cycle after reset.
- IDLE: `start`=1 → DRIVE. On that edge, LFSR←SEED, MISR←0 and the vector counter←0.
- DRIVE: registered outputs present the current LFSR vector: `a_out`=lfsr[BITS-1:0], `b_out`=lfsr[2BITS-1:BITS], `c_out`=lfsr[2BITS], `d_out`=lfsr[2BITS+1].
  - The LFSR advances once per DRIVE cycle. It is a Fibonacci LFSR with taps 16,14,13,11, shifting left, with feedback into bit 0.
  - After RUN_LEN vectors → DRAIN, or → DONE directly if LAT=0.
- DRAIN: stimulus outputs are 0. The state lasts exactly LAT cycles, then → DONE.
- DONE: `done`=1 and `signature` holds. → IDLE only when `start`=0. With `start` held high, the block stays in DONE and does not re-arm.
- `start` is ignored in DRIVE and DRAIN.
- Capture: a valid bit travels with each vector and is delayed LAT stages.
  - When the delayed bit is 1, the MISR updates: sig ← ({sig[14:0],1'b0} ^ (sig[15] ? 16'h6801 : 16'h0)) ^ {resp1_in, resp0_in} (right-aligned, zero-extended).
  - Otherwise the MISR holds.
  - Exactly RUN_LEN captures occur per run.
- Reset mid-run: on the next edge, state returns to IDLE, outputs and signature are 0, and the delay line is cleared. No stale captures occur afterwards.

## Timing
- `start` sampled at edge t0.
  - Vector k is on the outputs during cycle t0+1+k, for k = 0..RUN_LEN-1.
  - Response k is sampled at the edge ending cycle t0+1+k+LAT.
- `busy`=1 for cycles t0+1 .. t0+RUN_LEN+LAT.
- `done` rises at cycle t0+RUN_LEN+LAT+1.
- `signature` is final when `done` rises and is stable while `done`=1.
- Total run: RUN_LEN+LAT+1 cycles from `start` sample to `done`.

## Configuration
- `BM_STIM_CHECK_EN` defined: adds input `expected_sig` [15:0] and output `pass` [1].
  - `pass` = `done` & (`signature` == `expected_sig`), registered.
  - `pass` is 0 at reset and outside DONE.
- `BM_STIM_CHECK_EN` undefined: neither port exists and no comparator is built. All other behaviour is identical.

## Test plan
- Reset then `start`=1 with SEED=16'hACE1, BITS=2 → first vector at t0+1: `a_out`=2'b01, `b_out`=2'b00, `c_out`=0, `d_out`=1.
- RUN_LEN=4, LAT=3, `start` pulsed one cycle → `busy` high for exactly 7 cycles; `done` high at t0+8.
- Responses tied to 0, any RUN_LEN/LAT → `signature`=16'h0000 at `done`.
- RUN_LEN=1, LAT=0, `resp0_in`=2'b11, `resp1_in`=1 → `signature`=16'h0007 at t0+2.
- `reset_n`=0 for one cycle at t0+3 of a RUN_LEN=8 run → IDLE, `busy`=0 and `signature`=0 next cycle; no `done` until a fresh `start`.
- `start` held high through DONE → `done` stays 1 and no new run begins; dropping `start` → IDLE next cycle. With BM_STIM_CHECK_EN and `expected_sig`=16'h0007 in the RUN_LEN=1 case → `pass`=1.

Source files
------------

// File: rtl/bm_dag_stim_sig.sv
// bm_dag_stim_sig: LFSR stimulus driver and 16-bit MISR response
// compactor for the DAG micro-benchmarks.
//
// Ports:
//   clock, reset_n (sync, active-low), start (level run request)
//   a_out/b_out [BITS], c_out, d_out : registered operand stimulus
//   resp0_in [BITS], resp1_in         : benchmark out0/out1
//   busy, done, signature [16]        : run status and MISR contents
// Optional build: define BM_STIM_CHECK_EN to add expected_sig [16]
// and a registered pass flag.
module bm_dag_stim_sig #(
   parameter int          BITS    = 2,
   parameter logic [15:0] SEED    = 16'hACE1,
   parameter int          RUN_LEN = 64,
   parameter int          LAT     = 3
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   output logic [BITS-1:0] a_out,
   output logic [BITS-1:0] b_out,
   output logic            c_out,
   output logic            d_out,
   input  logic [BITS-1:0] resp0_in,
   input  logic            resp1_in,
   output logic            busy,
   output logic            done,
   output logic [15:0]     signature
`ifdef BM_STIM_CHECK_EN
   ,
   input  logic [15:0]     expected_sig,
   output logic            pass
`endif
);

   localparam int VW = 2 * BITS + 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
   localparam logic [15:0] LAST_VEC = 16'(RUN_LEN - 1);
   localparam logic [15:0] LAST_DRN = 16'(LAT - 1);
   localparam logic [1:0]  S_AFTER  = (LAT == 0) ? S_DONE : S_DRAIN;

   logic [1:0]    state, state_n;
   logic [15:0]   cnt, cnt_n;
   logic [15:0]   lfsr, lfsr_n;
   logic [15:0]   sig, sig_n;
   logic [VW-1:0] vec, vec_n;
   logic          drv;
   logic          cap;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   assign drv = (state == S_DRIVE);

   // Valid bit delayed LAT stages so each capture lines up with the
   // response to the vector presented LAT cycles earlier.
   generate
      if (LAT == 0) begin : g_nolat
         assign cap = drv;
      end else begin : g_lat
         logic [LAT-1:0] dl;
         always_ff @(posedge clock) begin
            if (!reset_n) dl <= '0;
            else          dl <= LAT'({dl, drv});
         end
         assign cap = dl[LAT-1];
      end
   endgenerate

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      lfsr_n  = lfsr;
      vec_n   = '0;
      sig_n   = sig;
      if (cap) begin
         sig_n = {sig[14:0], 1'b0}
               ^ (sig[15] ? 16'h6801 : 16'h0000)
               ^ 16'({resp1_in, resp0_in});
      end
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_DRIVE;
               cnt_n   = '0;
               vec_n   = SEED_EFF[VW-1:0];
               lfsr_n  = lfsr_step(SEED_EFF);
               sig_n   = '0;
            end
         end
         S_DRIVE: begin
            if (cnt == LAST_VEC) begin
               state_n = S_AFTER;
               cnt_n   = '0;
            end else begin
               cnt_n  = cnt + 16'd1;
               vec_n  = lfsr[VW-1:0];
               lfsr_n = lfsr_step(lfsr);
            end
         end
         S_DRAIN: begin
            if (cnt == LAST_DRN) state_n = S_DONE;
            else                 cnt_n   = cnt + 16'd1;
         end
         S_DONE: begin
            if (!start) state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         lfsr  <= '0;
         sig   <= '0;
         vec   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         lfsr  <= lfsr_n;
         sig   <= sig_n;
         vec   <= vec_n;
      end
   end

`ifdef BM_STIM_CHECK_EN
   // Built from next-state values so pass tracks DONE without lag.
   always_ff @(posedge clock) begin
      if (!reset_n) pass <= 1'b0;
      else          pass <= (state_n == S_DONE) && (sig_n == expected_sig);
   end
`endif

   assign a_out     = vec[BITS-1:0];
   assign b_out     = vec[2*BITS-1:BITS];
   assign c_out     = vec[2*BITS];
   assign d_out     = vec[2*BITS+1];
   assign busy      = (state == S_DRIVE) || (state == S_DRAIN);
   assign done      = (state == S_DONE);
   assign signature = sig;

endmodule

// File: tb/tb_bm_dag_stim_sig.sv
// tb_bm_dag_stim_sig: directed + randomized bench for bm_dag_stim_sig
// with a cycle-level reference model of stimulus and signature.
module tb_bm_dag_stim_sig;

   localparam int          RL   = 8;
   localparam int          LT   = 3;
   localparam int          TOT  = RL + LT + 1;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start, start1;
   logic [1:0]  a_out, b_out, a1, b1;
   logic        c_out, d_out, c1, d1;
   logic [1:0]  resp0, resp0_1;
   logic        resp1, resp1_1;
   logic        busy, done, busy1, done1;
   logic [15:0] signature, sig1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   bm_dag_stim_sig #(.BITS(2), .SEED(SEED), .RUN_LEN(RL), .LAT(LT)) u_dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
      .resp0_in(resp0), .resp1_in(resp1),
      .busy(busy), .done(done), .signature(signature)
   );

   bm_dag_stim_sig #(.BITS(2), .SEED(SEED), .RUN_LEN(1), .LAT(0)) u_one (
      .clock(clock), .reset_n(reset_n), .start(start1),
      .a_out(a1), .b_out(b1), .c_out(c1), .d_out(d1),
      .resp0_in(resp0_1), .resp1_in(resp1_1),
      .busy(busy1), .done(done1), .signature(sig1)
   );

   function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
      logic fb;
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      return {s[14:0], fb};
   endfunction

   function automatic logic [15:0] misr(input logic [15:0] s,
                                        input logic [2:0] r);
      logic [15:0] t;
      t = {s[14:0], 1'b0};
      if (s[15]) t = t ^ 16'h6801;
      return t ^ {13'd0, r};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_resp(input bit zero);
      if (zero) begin
         resp0 = 2'b00;
         resp1 = 1'b0;
      end else begin
         resp0 = 2'($urandom_range(0, 3));
         resp1 = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic idle_checks();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_vec", 32'({d_out, c_out, b_out, a_out}), 32'd0);
   endtask

   // Full run on the main instance; vector k expected in cycle t0+1+k,
   // response k folded from the value driven in cycle t0+1+k+LT.
   task automatic run_main(input bit zero, input bit hold);
      logic [15:0] v, sig_m;
      logic [5:0]  ev;
      int          k;
      start = 1'b1;
      set_resp(zero);
      tick();
      if (!hold) start = 1'b0;
      v     = SEED;
      sig_m = 16'h0;
      for (int j = 1; j <= TOT; j++) begin
         set_resp(zero);
         check("busy", 32'(busy), 32'(j <= RL + LT));
         check("done", 32'(done), 32'(j == TOT));
         ev = (j <= RL) ? v[5:0] : 6'd0;
         check("vec", 32'({d_out, c_out, b_out, a_out}), 32'(ev));
         if (j <= RL) v = lfsr_adv(v);
         k = j - 1 - LT;
         if (k >= 0 && k < RL) sig_m = misr(sig_m, {resp1, resp0});
         if (j == TOT) check("sig_final", 32'(signature), 32'(sig_m));
         tick();
      end
      if (hold) begin
         for (int j = 0; j < 3; j++) begin
            check("hold_done", 32'(done), 32'd1);
            check("hold_busy", 32'(busy), 32'd0);
            check("hold_sig", 32'(signature), 32'(sig_m));
            tick();
         end
         start = 1'b0;
         tick();
      end
      idle_checks();
   endtask

   task automatic mid_reset(input int at);
      start = 1'b1;
      set_resp(1'b0);
      tick();
      start = 1'b0;
      for (int j = 1; j < at; j++) begin
         set_resp(1'b0);
         tick();
      end
      check("pre_rst_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      idle_checks();
      check("rst_sig", 32'(signature), 32'd0);
      for (int j = 0; j < 16; j++) begin
         set_resp(1'b0);
         check("post_rst_done", 32'(done), 32'd0);
         check("post_rst_sig", 32'(signature), 32'd0);
         tick();
      end
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      start1  = 1'b0;
      resp0   = 2'b00;
      resp1   = 1'b0;
      resp0_1 = 2'b11;
      resp1_1 = 1'b1;
      tick();
      tick();
      idle_checks();
      check("rst_sig", 32'(signature), 32'd0);
      check("rst_one", 32'({busy1, done1, sig1}), 32'd0);
      reset_n = 1'b1;
      tick();
      idle_checks();
      check("post_rst_sig", 32'(signature), 32'd0);

      start = 1'b1;
      tick();
      start = 1'b0;
      check("first_a", 32'(a_out), 32'd1);
      check("first_b", 32'(b_out), 32'd0);
      check("first_c", 32'(c_out), 32'd0);
      check("first_d", 32'(d_out), 32'd1);
      while (busy || done) tick();

      run_main(1'b0, 1'b0);
      run_main(1'b1, 1'b0);
      check("zero_sig", 32'(signature), 32'd0);
      run_main(1'b0, 1'b1);
      run_main(1'b0, 1'b0);

      mid_reset(3);
      mid_reset(9);
      run_main(1'b0, 1'b0);

      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("one_busy", 32'(busy1), 32'd1);
      check("one_vec", 32'({d1, c1, b1, a1}), 32'h21);
      tick();
      check("one_done", 32'(done1), 32'd1);
      check("one_busy2", 32'(busy1), 32'd0);
      check("one_sig", 32'(sig1), 32'h0007);
      tick();
      check("one_idle", 32'(done1), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
